// File: rtl/sw_reader_if.sv
// Switch-reader bus: raw switch input, debounced level and change-event handshake.
interface sw_reader_if;
  logic [7:0] sw;
  logic [7:0] ld;
  logic [7:0] sw_val;
  logic [7:0] sw_rise;
  logic [7:0] sw_fall;
  logic       sw_valid;
  logic       sw_ready;
  logic       sw_ovf;

  // Consumer side: drives the switches and the accept strobe.
  modport master (
    output sw, sw_ready,
    input  ld, sw_val, sw_rise, sw_fall, sw_valid, sw_ovf
  );

  // Reader side: samples the switches and presents debounced state and events.
  modport slave (
    input  sw, sw_ready,
    output ld, sw_val, sw_rise, sw_fall, sw_valid, sw_ovf
  );
endinterface

// File: rtl/sw_reader.sv
// Eight-switch debouncer with a change-event register. Each switch is
// synchronized, then must differ from its debounced level for STABLE_CYCLES
// consecutive cycles before the level flips. Flips raise an event carrying the
// new value and rise/fall masks; events that arrive before the consumer takes
// the pending one are merged into it and flagged as an overflow.
module sw_reader #(
  parameter int unsigned STABLE_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  sw_reader_if.slave  bus
);

  localparam int unsigned     CW      = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);

  logic [7:0]          s1_q, s1_d;
  logic [7:0]          s2_q, s2_d;
  logic [7:0][CW-1:0]  cnt_q, cnt_d;
  logic [7:0]          deb_q, deb_d;
  logic [7:0]          val_q, val_d;
  logic [7:0]          rise_q, rise_d;
  logic [7:0]          fall_q, fall_d;
  logic                valid_q, valid_d;
  logic                ovf_q, ovf_d;

  logic [7:0]          evt_rise;
  logic [7:0]          evt_fall;
  logic                evt;

  // Two-flop synchronizer: nothing downstream looks at the raw switches.
  always_comb begin
    s1_d = bus.sw;
    s2_d = s1_q;
  end

  // Per-bit stability counters: count while the synchronized level disagrees,
  // flip the debounced bit on the final disagreeing cycle.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    cnt_d = cnt_q;
    deb_d = deb_q;
    for (int i = 0; i < 8; i++) begin
      if (s2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        deb_d[i] = ~deb_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_ONE;
      end
    end
  end

  assign evt_rise = deb_d & ~deb_q;
  assign evt_fall = ~deb_d & deb_q;
  assign evt      = |(evt_rise | evt_fall);

  // Event register: load a fresh event, merge into an unaccepted one, or retire on accept.
  always_comb begin
    val_d   = val_q;
    rise_d  = rise_q;
    fall_d  = fall_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    if (evt) begin
      val_d   = deb_d;
      valid_d = 1'b1;
      if (valid_q && !bus.sw_ready) begin
        rise_d = rise_q | evt_rise;
        fall_d = fall_q | evt_fall;
        ovf_d  = 1'b1;
      end else begin
        rise_d = evt_rise;
        fall_d = evt_fall;
      end
    end else if (valid_q && bus.sw_ready) begin
      valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset; reset discards in-flight debounce and events.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every flop samples the values from before this edge.
    if (rst) begin
      s1_q    <= '0;
      s2_q    <= '0;
      cnt_q   <= '0;
      deb_q   <= '0;
      val_q   <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      cnt_q   <= cnt_d;
      deb_q   <= deb_d;
      val_q   <= val_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.ld       = deb_q;
  assign bus.sw_val   = val_q;
  assign bus.sw_rise  = rise_q;
  assign bus.sw_fall  = fall_q;
  assign bus.sw_valid = valid_q;
  assign bus.sw_ovf   = ovf_q;

endmodule

// File: tb/tb_sw_reader.sv
// Bench for sw_reader with STABLE_CYCLES = 4. A reference model tracks a
// window of the last N synchronized samples: a debounced bit flips when all N
// samples in the window disagree with it.
module tb_sw_reader;

  localparam int N = 4;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  sw_reader_if bus();

  sw_reader #(.STABLE_CYCLES(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0][7:0] hist;   // hist[0] is the newest synchronized sample
    logic [7:0]        s1;
    logic [7:0]        s2;
    logic [7:0]        ld;
    logic [7:0]        val;
    logic [7:0]        rise;
    logic [7:0]        fall;
    logic              valid;
    logic              ovf;
  } mstate_t;

  mstate_t m = '0;

  function automatic mstate_t model_next(mstate_t cur, logic r, logic [7:0] s, logic rdy);
    mstate_t    nx;
    logic [7:0] new_ld;
    logic [7:0] r_m;
    logic [7:0] f_m;
    logic       all_diff;
    nx = cur;
    if (r) begin
      nx = '0;
    end else begin
      nx.hist = {cur.hist[N-2:0], cur.s2};
      new_ld  = cur.ld;
      for (int i = 0; i < 8; i++) begin
        all_diff = 1'b1;
        for (int k = 0; k < N; k++)
          if (nx.hist[k][i] == cur.ld[i]) all_diff = 1'b0;
        if (all_diff) new_ld[i] = ~cur.ld[i];
      end
      r_m = new_ld & ~cur.ld;
      f_m = cur.ld & ~new_ld;
      if (new_ld != cur.ld) begin
        nx.val   = new_ld;
        nx.valid = 1'b1;
        if (cur.valid && !rdy) begin
          nx.rise = cur.rise | r_m;
          nx.fall = cur.fall | f_m;
          nx.ovf  = 1'b1;
        end else begin
          nx.rise = r_m;
          nx.fall = f_m;
        end
      end else if (cur.valid && rdy) begin
        nx.valid = 1'b0;
      end
      nx.ld = new_ld;
      nx.s2 = cur.s1;
      nx.s1 = s;
    end
    return nx;
  endfunction

  always @(posedge clk) m <= model_next(m, rst, bus.sw, bus.sw_ready);

  logic [33:0] dut_vec;
  logic [33:0] exp_vec;
  assign dut_vec = {bus.ld, bus.sw_val, bus.sw_rise, bus.sw_fall, bus.sw_valid, bus.sw_ovf};
  assign exp_vec = {m.ld, m.val, m.rise, m.fall, m.valid, m.ovf};

  // Advance n clock cycles; returns on the falling edge, where outputs are sampled.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    bus.sw      = 8'h00;
    bus.sw_ready = 1'b0;
    step(3);
    checks++;
    if (dut_vec !== 34'h0) begin
      errors++;
      $display("FAIL reset_state got %h want %h", dut_vec, 34'h0);
    end
    rst = 1'b0;
    for (int c = 0; c < 50; c++) begin
      step(1);
      checks++;
      if ({bus.ld, bus.sw_valid, bus.sw_ovf} !== 10'h0) begin
        errors++;
        $display("FAIL idle_zero cyc=%0d got ld=%h v=%b o=%b want 0", c, bus.ld, bus.sw_valid, bus.sw_ovf);
      end
    end
    checks++;
    if (dut_vec !== exp_vec) begin
      errors++;
      $display("FAIL idle_model got %h want %h", dut_vec, exp_vec);
    end
  endtask

  task automatic test_glitch();
    bus.sw = 8'h01;
    step(3);
    bus.sw = 8'h00;
    for (int c = 0; c < 10; c++) begin
      step(1);
      checks++;
      if ({bus.ld, bus.sw_valid} !== 9'h0) begin
        errors++;
        $display("FAIL glitch cyc=%0d got ld=%h v=%b want ld=00 v=0", c, bus.ld, bus.sw_valid);
      end
    end
  endtask

  task automatic test_single_event();
    bus.sw_ready = 1'b0;
    bus.sw       = 8'h55;
    step(5);
    checks++;
    if (bus.ld !== 8'h00 || bus.sw_valid !== 1'b0) begin
      errors++;
      $display("FAIL early_edge5 got ld=%h v=%b want ld=00 v=0", bus.ld, bus.sw_valid);
    end
    step(1);
    checks++;
    if ({bus.ld, bus.sw_valid, bus.sw_val, bus.sw_rise, bus.sw_fall} !== {8'h55, 1'b1, 8'h55, 8'h55, 8'h00}) begin
      errors++;
      $display("FAIL event_edge6 got ld=%h v=%b val=%h r=%h f=%h want 55 1 55 55 00",
               bus.ld, bus.sw_valid, bus.sw_val, bus.sw_rise, bus.sw_fall);
    end
    bus.sw_ready = 1'b1;
    step(1);
    bus.sw_ready = 1'b0;
    checks++;
    if (bus.sw_valid !== 1'b0 || bus.sw_val !== 8'h55) begin
      errors++;
      $display("FAIL accept got v=%b val=%h want v=0 val=55", bus.sw_valid, bus.sw_val);
    end
    checks++;
    if (dut_vec !== exp_vec) begin
      errors++;
      $display("FAIL single_model got %h want %h", dut_vec, exp_vec);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    bus.sw_ready = 1'b0;
    bus.sw       = 8'h55;
    step(8);
    bus.sw = 8'hAA;
    step(8);
    checks++;
    if ({bus.sw_val, bus.sw_rise, bus.sw_fall, bus.sw_ovf, bus.sw_valid} !== {8'hAA, 8'hFF, 8'h55, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL overflow got val=%h r=%h f=%h o=%b v=%b want AA FF 55 1 1",
               bus.sw_val, bus.sw_rise, bus.sw_fall, bus.sw_ovf, bus.sw_valid);
    end
    step(3);
    checks++;
    if (bus.sw_ovf !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky got %b want 1", bus.sw_ovf);
    end
  endtask

  task automatic test_ready_on_event();
    do_reset();
    bus.sw_ready = 1'b0;
    bus.sw       = 8'h55;
    step(8);
    bus.sw = 8'hAA;
    step(5);
    checks++;
    if (bus.ld !== 8'h55 || bus.sw_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_second got ld=%h v=%b want 55 1", bus.ld, bus.sw_valid);
    end
    bus.sw_ready = 1'b1;
    step(1);
    bus.sw_ready = 1'b0;
    checks++;
    if ({bus.sw_valid, bus.sw_val, bus.sw_rise, bus.sw_fall, bus.sw_ovf} !== {1'b1, 8'hAA, 8'hAA, 8'h55, 1'b0}) begin
      errors++;
      $display("FAIL ready_on_event got v=%b val=%h r=%h f=%h o=%b want 1 AA AA 55 0",
               bus.sw_valid, bus.sw_val, bus.sw_rise, bus.sw_fall, bus.sw_ovf);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.sw_ready = 1'b0;
    bus.sw       = 8'hFF;
    step(3);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step(1);
      checks++;
      if (bus.ld !== 8'h00 || bus.sw_valid !== 1'b0) begin
        errors++;
        $display("FAIL in_reset cyc=%0d got ld=%h v=%b want 00 0", c, bus.ld, bus.sw_valid);
      end
    end
    rst = 1'b0;
    step(5);
    checks++;
    if (bus.ld !== 8'h00) begin
      errors++;
      $display("FAIL post_rst_edge5 got ld=%h want 00", bus.ld);
    end
    step(1);
    checks++;
    if ({bus.ld, bus.sw_valid, bus.sw_rise} !== {8'hFF, 1'b1, 8'hFF}) begin
      errors++;
      $display("FAIL post_rst_edge6 got ld=%h v=%b r=%h want FF 1 FF", bus.ld, bus.sw_valid, bus.sw_rise);
    end
  endtask

  task automatic test_random();
    logic [7:0] val;
    int         hold;
    do_reset();
    val = 8'h00;
    for (int seg = 0; seg < 300; seg++) begin
      if ($urandom_range(0, 1) == 0) val = 8'($urandom());
      else                           val = val ^ (8'h01 << $urandom_range(0, 7));
      bus.sw = val;
      hold = $urandom_range(1, 7);
      for (int h = 0; h < hold; h++) begin
        bus.sw_ready = ($urandom_range(0, 2) == 0);
        rst          = ($urandom_range(0, 249) == 0);
        step(1);
        checks++;
        if (dut_vec !== exp_vec) begin
          errors++;
          $display("FAIL random seg=%0d got %h want %h", seg, dut_vec, exp_vec);
        end
      end
    end
    rst          = 1'b0;
    bus.sw_ready = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    bus.sw       = 8'h00;
    bus.sw_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_glitch();
    test_single_event();
    test_overflow();
    test_ready_on_event();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
